// File: rtl/uart_pkg.sv
// Definitions shared by both ends of the UART link: receiver FSM states and CRC-8/SMBUS.
// The transmitter imports this package too, so the polynomial and init value live only here.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One byte of CRC-8, MSB first, no reflection and no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter so
// an idle-high line does not look like a start bit while reset is released.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver_system.sv
// 8N1 UART receiver: mid-bit sampling FSM, single-byte holding register with valid/read
// handshake, running CRC-8 over accepted bytes and sticky frame/overrun error flags.
module uart_receiver_system
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  input  logic       read,
  input  logic       clear,
  output logic [7:0] data_out,
  output logic       valid,
  output logic [7:0] crc8,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_s;
  rx_state_e        state_q;
  logic [CNT_W-1:0] bitCnt_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       shiftReg_q;
  logic [7:0]       dataOut_q, dataOut_d;
  logic             valid_q, valid_d;
  logic [7:0]       crc_q, crc_d, crcBase;
  logic             frameErr_q, frameErr_d;
  logic             overrun_q, overrun_d;
  logic             stopSample, accept, take, frameErrSet, overrunSet;

  bit_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (data_in),
    .q_o   (rx_s)
  );

  assign stopSample  = (state_q == STOP) && (bitCnt_q == BIT_END);
  assign accept      = stopSample && rx_s;
  assign frameErrSet = stopSample && !rx_s;
  assign take        = accept && (!valid_q || read);
  assign overrunSet  = accept && !take;

  // clear restarts the CRC; a byte accepted in the same cycle seeds the fresh CRC.
  assign crcBase    = clear ? CRC8_INIT : crc_q;
  assign crc_d      = take ? crc8_byte(crcBase, shiftReg_q) : crcBase;
  assign dataOut_d  = take ? shiftReg_q : dataOut_q;
  assign valid_d    = take ? 1'b1 : (valid_q && !read);
  assign frameErr_d = frameErrSet | (frameErr_q & ~clear);
  assign overrun_d  = overrunSet | (overrun_q & ~clear);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      bitIdx_q   <= '0;
      shiftReg_q <= '0;
      dataOut_q  <= '0;
      valid_q    <= 1'b0;
      crc_q      <= CRC8_INIT;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      dataOut_q  <= dataOut_d;
      valid_q    <= valid_d;
      crc_q      <= crc_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q  <= START;
            bitCnt_q <= '0;
          end
        end
        // A start bit must still be low half a bit later, otherwise it was a glitch.
        START: begin
          if (bitCnt_q == HALF_END) begin
            bitCnt_q <= '0;
            bitIdx_q <= '0;
            state_q  <= rx_s ? IDLE : DATA;
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bitCnt_q == BIT_END) begin
            shiftReg_q[bitIdx_q] <= rx_s;
            bitCnt_q             <= '0;
            bitIdx_q             <= bitIdx_q + 1'b1;
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bitCnt_q == BIT_END) begin
            bitCnt_q <= '0;
            state_q  <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end
        // A low stop bit may be a break; wait for the line to return high first.
        WAIT_IDLE: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out    = dataOut_q;
  assign valid       = valid_q;
  assign crc8        = crc_q;
  assign frame_error = frameErr_q;
  assign overrun     = overrun_q;

endmodule
